sha256_block_engine: RTL

//  Stream-side SHA-256/224 compression engine: the responder for the miner's block stream.

---
 rtl/sha256_block_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sha256_block_engine.sv
// SHA-256/224 compression engine. Takes padded 512-bit blocks from a stream,
// chains the hash state across a message, and holds each digest as a level.
module sha256_block_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         mode,
    input  logic [511:0] s_tdata_i,
    input  logic         s_tlast_i,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    output logic [255:0] digest_o,
    output logic         digest_valid_o,
    output logic         digest_last_o
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

    localparam logic [0:7][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [0:7][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] T_LAST = 6'(64 - UNROLL);
    localparam logic [5:0] T_STEP = 6'(UNROLL);

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(
        input logic [31:0] e, input logic [31:0] f, input logic [31:0] g
    );
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c
    );
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t            state_q;
    logic [0:7][31:0]  st_q, st_d;
    logic [0:7][31:0]  h_q, h_d;
    logic [0:7][31:0]  iv;
    logic [0:15][31:0] w_q, w_d;
    logic [5:0]        t_q;
    logic              first_q;
    logic              last_q;
    logic              mode_q;
    logic              ready_q;
    logic              dvalid_q;
    logic              dlast_q;
    logic [255:0]      digest_q;
    logic [31:0]       t1, t2, wn;

    // a..h live at indices 0..7; w_q[0] is always W[t] for the current round.
    always_comb begin
        st_d = st_q;
        w_d  = w_q;
        t1   = '0;
        t2   = '0;
        wn   = '0;
        for (int u = 0; u < UNROLL; u++) begin
            t1 = st_d[7] + bsig1(st_d[4]) + ch(st_d[4], st_d[5], st_d[6])
               + K[t_q + 6'(u)] + w_d[0];
            t2 = bsig0(st_d[0]) + maj(st_d[0], st_d[1], st_d[2]);
            wn = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
            st_d = {t1 + t2, st_d[0:2], st_d[3] + t1, st_d[4:6]};
            w_d  = {w_d[1:15], wn};
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_d[i] = h_q[i] + st_q[i];
        end
        iv = mode_q ? IV256 : IV224;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            digest_q <= '0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            mode_q   <= 1'b1;
            t_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The block is captured here so the source may move on at once.
                    if (s_tvalid_i) begin
                        w_q      <= s_tdata_i;
                        last_q   <= s_tlast_i;
                        if (first_q) mode_q <= mode;
                        ready_q  <= 1'b0;
                        dvalid_q <= 1'b0;
                        dlast_q  <= 1'b0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (first_q) begin
                        h_q  <= iv;
                        st_q <= iv;
                    end else begin
                        st_q <= h_q;
                    end
                    t_q     <= '0;
                    state_q <= ROUND;
                end
                ROUND: begin
                    st_q <= st_d;
                    w_q  <= w_d;
                    t_q  <= t_q + T_STEP;
                    if (t_q == T_LAST) state_q <= FINAL;
                end
                FINAL: begin
                    h_q      <= h_d;
                    digest_q <= mode_q ? h_d : {h_d[0:6], 32'h0};
                    dvalid_q <= 1'b1;
                    dlast_q  <= last_q;
                    first_q  <= last_q;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign s_tready_o     = ready_q;
    assign digest_o       = digest_q;
    assign digest_valid_o = dvalid_q;
    assign digest_last_o  = dlast_q;

endmodule
